game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller.sv | 149 ++++++++++++++
 tb/tb_game_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Reaction game round controller: arms an external 5-bit down-counter, captures
// the player's stop value, judges it against a latched target and displays a
// blinking win/lose result for FLASH_CYCLES cycles of the 4 Hz game clock.
// Optional feature: define GAME_CONTROLLER_SCORE_EN to keep a saturating
// 4-bit win counter on score_o; otherwise score_o is tied to zero.
module game_controller #(
    parameter int unsigned FLASH_CYCLES = 8
) (
    input  logic       clk_4_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic [4:0] target_i,
    input  logic [4:0] count_i,
    output logic       count_reload_o,
    output logic       en_o,
    output logic       busy_o,
    output logic       win_o,
    output logic       lose_o,
    output logic       flash_o,
    output logic [4:0] captured_o,
    output logic [3:0] score_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_JUDGE,
        S_WIN,
        S_LOSE
    } state_t;

    // Result display counts down from FLASH_CYCLES-1 to 0, so the result
    // state lasts exactly FLASH_CYCLES cycles.
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [4:0] target_q;
    logic [4:0] captured_q;
    logic [7:0] flash_cnt;
    logic       flash_q;
    logic       in_result;
    logic       enter_result;

    // State register.
    always_ff @(posedge clk_4_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next     = state;
        count_reload_o = 1'b0;
        en_o           = 1'b0;
        busy_o         = 1'b1;
        win_o          = 1'b0;
        lose_o         = 1'b0;
        in_result      = 1'b0;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_next = S_ARM;
            end
            S_ARM: begin
                count_reload_o = 1'b1;
                state_next     = S_RUN;
            end
            S_RUN: begin
                en_o = 1'b1;
                // A stop in the same cycle as count 0 wins over the timeout.
                if (stop_i)              state_next = S_JUDGE;
                else if (count_i == 5'd0) state_next = S_LOSE;
            end
            S_JUDGE: begin
                state_next = (captured_q == target_q) ? S_WIN : S_LOSE;
            end
            S_WIN: begin
                win_o     = 1'b1;
                in_result = 1'b1;
                if (flash_cnt == 8'd0) state_next = S_IDLE;
            end
            S_LOSE: begin
                lose_o    = 1'b1;
                in_result = 1'b1;
                if (flash_cnt == 8'd0) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        enter_result = !in_result &&
                       ((state_next == S_WIN) || (state_next == S_LOSE));
    end

    // Round datapath: target/capture latches and the result flash timer.
    always_ff @(posedge clk_4_i) begin
        if (rst_i) begin
            target_q   <= '0;
            captured_q <= '0;
            flash_cnt  <= '0;
            flash_q    <= 1'b0;
        end else begin
            if ((state == S_IDLE) && start_i) target_q <= target_i;
            if ((state == S_RUN) && stop_i)   captured_q <= count_i;
            if (enter_result) begin
                flash_cnt <= FLASH_LAST;
                flash_q   <= 1'b1;
            end else if (in_result && (flash_cnt != 8'd0)) begin
                flash_cnt <= flash_cnt - 8'd1;
                flash_q   <= ~flash_q;
            end else begin
                flash_cnt <= '0;
                flash_q   <= 1'b0;
            end
        end
    end

    assign captured_o = captured_q;
    assign flash_o    = flash_q;

`ifdef GAME_CONTROLLER_SCORE_EN
    logic [3:0] score_q;

    // Saturating win counter, cleared only by reset.
    always_ff @(posedge clk_4_i) begin
        if (rst_i) begin
            score_q <= '0;
        end else if ((state == S_JUDGE) && (state_next == S_WIN) &&
                     (score_q != 4'd15)) begin
            score_q <= score_q + 4'd1;
        end
    end

    assign score_o = score_q;
`else
    assign score_o = 4'd0;
`endif

endmodule

// File: tb/tb_game_controller.sv
// Directed testbench for game_controller. The bench plays the external
// down-counter itself (reload to 31, decrement while enabled, wrap 0->31)
// and checks every output against hand-derived values.
`timescale 1ns/1ps
module tb_game_controller;

    localparam int FLASH = 8;

    logic       clk_4_i;
    logic       rst_i;
    logic       start_i;
    logic       stop_i;
    logic [4:0] target_i;
    logic [4:0] count_i;
    logic       count_reload_o;
    logic       en_o;
    logic       busy_o;
    logic       win_o;
    logic       lose_o;
    logic       flash_o;
    logic [4:0] captured_o;
    logic [3:0] score_o;

    int n_total;
    int n_bad;
    int exp_score;

    game_controller #(.FLASH_CYCLES(FLASH)) dut (
        .clk_4_i        (clk_4_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .target_i       (target_i),
        .count_i        (count_i),
        .count_reload_o (count_reload_o),
        .en_o           (en_o),
        .busy_o         (busy_o),
        .win_o          (win_o),
        .lose_o         (lose_o),
        .flash_o        (flash_o),
        .captured_o     (captured_o),
        .score_o        (score_o)
    );

    initial clk_4_i = 1'b0;
    always #5 clk_4_i = ~clk_4_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock: counter model reacts to the reload/enable seen before the edge.
    task automatic step();
        logic rl;
        logic e;
        rl = count_reload_o;
        e  = en_o;
        @(posedge clk_4_i);
        @(negedge clk_4_i);
        if (rl)     count_i = 5'd31;
        else if (e) count_i = count_i - 5'd1;
    endtask

    task automatic start_round(input logic [4:0] tgt);
        target_i = tgt;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
        check("arm_reload", count_reload_o, 1);
        check("arm_en", en_o, 0);
        step();
        check("run_en", en_o, 1);
    endtask

    task automatic run_to(input logic [4:0] c);
        int guard;
        guard = 0;
        while ((count_i != c) && (guard < 40)) begin
            step();
            guard++;
        end
        check("run_to", count_i, c);
    endtask

    task automatic stop_now();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check("judge_busy", busy_o, 1);
        check("judge_win", win_o, 0);
        check("judge_lose", lose_o, 0);
    endtask

    // Checks FLASH result cycles starting at the current one, then IDLE.
    task automatic check_result(input logic is_win, input int start_at);
        for (int i = 0; i < FLASH; i++) begin
            check("res_win", win_o, is_win);
            check("res_lose", lose_o, !is_win);
            check("res_flash", flash_o, (i % 2 == 0));
            check("res_en", en_o, 0);
            if (i == start_at) start_i = 1'b1;
            step();
            start_i = 1'b0;
        end
        check("idle_busy", busy_o, 0);
        check("idle_win", win_o, 0);
        check("idle_lose", lose_o, 0);
        check("idle_flash", flash_o, 0);
    endtask

    task automatic note_win();
`ifdef GAME_CONTROLLER_SCORE_EN
        if (exp_score < 15) exp_score++;
`endif
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        exp_score = 0;
        rst_i     = 1'b1;
        start_i   = 1'b0;
        stop_i    = 1'b0;
        target_i  = 5'd0;
        count_i   = 5'd31;
        @(negedge clk_4_i);
        step();
        step();
        rst_i = 1'b0;
        check("rst_busy", busy_o, 0);
        check("rst_en", en_o, 0);
        check("rst_reload", count_reload_o, 0);
        check("rst_win", win_o, 0);
        check("rst_lose", lose_o, 0);
        check("rst_flash", flash_o, 0);
        check("rst_captured", captured_o, 0);
        check("rst_score", score_o, 0);

        // Stop ignored in IDLE.
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check("idle_stop_busy", busy_o, 0);

        // Win: target 20, stop at count 20.
        start_round(5'd20);
        run_to(5'd20);
        stop_now();
        check("win_captured", captured_o, 20);
        step();
        note_win();
        check_result(1'b1, -1);
        check("win_score", score_o, exp_score);

        // Miss: target 5 latched, then target_i changes to 6; stop at 6.
        start_round(5'd5);
        target_i = 5'd6;
        run_to(5'd6);
        stop_now();
        check("miss_captured", captured_o, 6);
        step();
        check_result(1'b0, -1);
        check("miss_score", score_o, exp_score);

        // Timeout: no stop, lose on the cycle after count 0.
        start_round(5'd3);
        run_to(5'd0);
        check("to_en_at0", en_o, 1);
        check("to_lose_at0", lose_o, 0);
        step();
        check("to_en", en_o, 0);
        check("to_captured", captured_o, 6);
        check_result(1'b0, -1);

        // Stop together with count 0, target 0: stop wins.
        start_round(5'd0);
        run_to(5'd0);
        stop_now();
        check("sim_captured", captured_o, 0);
        step();
        note_win();
        check_result(1'b1, -1);

        // Reset mid-RUN at count 17.
        start_round(5'd9);
        run_to(5'd17);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        exp_score = 0;
        check("mid_busy", busy_o, 0);
        check("mid_en", en_o, 0);
        check("mid_reload", count_reload_o, 0);
        check("mid_win", win_o, 0);
        check("mid_lose", lose_o, 0);
        check("mid_flash", flash_o, 0);
        check("mid_captured", captured_o, 0);
        check("mid_score", score_o, 0);

        // Start accepted right after reset; start pulse in WIN ignored.
        start_round(5'd31);
        stop_now();
        check("pw_captured", captured_o, 31);
        step();
        note_win();
        check_result(1'b1, 2);
        step();
        check("pw_stay_idle", busy_o, 0);

        // Sixteen quick wins: score saturates (or stays 0 without the feature).
        for (int r = 0; r < 16; r++) begin
            start_round(5'd31);
            stop_now();
            step();
            note_win();
            check_result(1'b1, -1);
            check("sat_score", score_o, exp_score);
        end
`ifdef GAME_CONTROLLER_SCORE_EN
        check("sat_final", score_o, 15);
`else
        check("sat_final", score_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
